axi_mem_tester: RTL and testbench

AXI_MEM_TESTER -- requirements
Module: axi_mem_tester

---
 rtl/axi_mem_tester.sv | 187 ++++++++++++++++++
 tb/tb_axi_mem_tester.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_tester.sv
// AXI4 memory tester: writes address-derived patterns in INCR bursts, reads
// each burst back, and counts beats whose data or response is wrong.
module axi_mem_tester #(
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 64,
  parameter int ID_BITS   = 5,
  parameter int STRB_BITS = DATA_BITS/8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [7:0]           burst_len,
  input  logic [15:0]          num_bursts,
  input  logic [31:0]          seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  input  logic                 axi_aw_ready,
  output logic                 axi_aw_valid,
  output logic [ADDR_BITS-1:0] axi_aw_bits_addr,
  output logic [7:0]           axi_aw_bits_len,
  output logic [2:0]           axi_aw_bits_size,
  output logic [1:0]           axi_aw_bits_burst,
  output logic                 axi_aw_bits_lock,
  output logic [3:0]           axi_aw_bits_cache,
  output logic [2:0]           axi_aw_bits_prot,
  output logic [3:0]           axi_aw_bits_qos,
  output logic [ID_BITS-1:0]   axi_aw_bits_id,
  input  logic                 axi_w_ready,
  output logic                 axi_w_valid,
  output logic [DATA_BITS-1:0] axi_w_bits_data,
  output logic [STRB_BITS-1:0] axi_w_bits_strb,
  output logic                 axi_w_bits_last,
  output logic                 axi_b_ready,
  input  logic                 axi_b_valid,
  input  logic [1:0]           axi_b_bits_resp,
  input  logic [ID_BITS-1:0]   axi_b_bits_id,
  input  logic                 axi_ar_ready,
  output logic                 axi_ar_valid,
  output logic [ADDR_BITS-1:0] axi_ar_bits_addr,
  output logic [7:0]           axi_ar_bits_len,
  output logic [2:0]           axi_ar_bits_size,
  output logic [1:0]           axi_ar_bits_burst,
  output logic                 axi_ar_bits_lock,
  output logic [3:0]           axi_ar_bits_cache,
  output logic [2:0]           axi_ar_bits_prot,
  output logic [3:0]           axi_ar_bits_qos,
  output logic [ID_BITS-1:0]   axi_ar_bits_id,
  output logic                 axi_r_ready,
  input  logic                 axi_r_valid,
  input  logic [DATA_BITS-1:0] axi_r_bits_data,
  input  logic [1:0]           axi_r_bits_resp,
  input  logic                 axi_r_bits_last,
  input  logic [ID_BITS-1:0]   axi_r_bits_id
);

  localparam int BYTES     = DATA_BITS/8;
  localparam int LOG_BYTES = $clog2(BYTES);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;
  state_t state, next_state;

  logic [7:0]           len_q;
  logic [15:0]          nb_q;
  logic [15:0]          burst_idx;
  logic [31:0]          seed_q;
  logic [7:0]           beat;
  logic [ADDR_BITS-1:0] burst_addr;
  logic [ADDR_BITS-1:0] beat_addr;
  logic [ADDR_BITS-1:0] burst_step;
  logic [31:0]          pattern;
  logic [DATA_BITS-1:0] exp_data;
  logic beat_last, r_end, last_burst;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic b_err, r_err, err_hit;

  // Beat address is derived from the burst base, so payloads stay stable while stalled.
  assign beat_addr  = burst_addr + (ADDR_BITS'(beat) << LOG_BYTES);
  assign burst_step = ADDR_BITS'({1'b0, len_q} + 9'd1) << LOG_BYTES;
  assign pattern    = 32'(beat_addr) ^ seed_q;
  assign exp_data   = {(DATA_BITS/32){pattern}};
  assign beat_last  = (beat == len_q);
  assign r_end      = beat_last || axi_r_bits_last;
  assign last_burst = ((burst_idx + 16'd1) == nb_q);

  assign aw_hs = (state == AW) && axi_aw_ready;
  assign w_hs  = (state == W)  && axi_w_ready;
  assign b_hs  = (state == B)  && axi_b_valid;
  assign ar_hs = (state == AR) && axi_ar_ready;
  assign r_hs  = (state == R)  && axi_r_valid;

  // All error causes on one beat collapse into a single count.
  assign b_err   = (axi_b_bits_resp != 2'b00) || (axi_b_bits_id != '0);
  assign r_err   = (axi_r_bits_data != exp_data) || (axi_r_bits_resp != 2'b00) ||
                   (axi_r_bits_id != '0) || (axi_r_bits_last != beat_last);
  assign err_hit = (b_hs && b_err) || (r_hs && r_err);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = (num_bursts == '0) ? DONE : AW;
      AW:      if (axi_aw_ready) next_state = W;
      W:       if (axi_w_ready && beat_last) next_state = B;
      B:       if (axi_b_valid) next_state = AR;
      AR:      if (axi_ar_ready) next_state = R;
      R:       if (axi_r_valid && r_end) next_state = last_burst ? DONE : AW;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    done         = (state == DONE);
    axi_aw_valid = (state == AW);
    axi_w_valid  = (state == W);
    axi_b_ready  = (state == B);
    axi_ar_valid = (state == AR);
    axi_r_ready  = (state == R);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q      <= '0;
      nb_q       <= '0;
      seed_q     <= '0;
      burst_addr <= '0;
      burst_idx  <= '0;
      beat       <= '0;
      pass       <= 1'b0;
      err_count  <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        len_q      <= burst_len;
        nb_q       <= num_bursts;
        seed_q     <= seed;
        burst_addr <= base_addr;
        burst_idx  <= '0;
        beat       <= '0;
        pass       <= 1'b1;
        err_count  <= '0;
      end
      if (aw_hs || ar_hs) beat <= '0;
      if (w_hs || r_hs)   beat <= beat + 8'd1;
      if (r_hs && r_end) begin
        burst_addr <= burst_addr + burst_step;
        burst_idx  <= burst_idx + 16'd1;
      end
      if (err_hit) begin
        pass <= 1'b0;
        if (err_count != '1) err_count <= err_count + 16'd1;
      end
    end
  end

  assign axi_aw_bits_addr  = burst_addr;
  assign axi_aw_bits_len   = len_q;
  assign axi_aw_bits_size  = 3'(LOG_BYTES);
  assign axi_aw_bits_burst = 2'b01;
  assign axi_aw_bits_lock  = 1'b0;
  assign axi_aw_bits_cache = '0;
  assign axi_aw_bits_prot  = '0;
  assign axi_aw_bits_qos   = '0;
  assign axi_aw_bits_id    = '0;

  assign axi_ar_bits_addr  = burst_addr;
  assign axi_ar_bits_len   = len_q;
  assign axi_ar_bits_size  = 3'(LOG_BYTES);
  assign axi_ar_bits_burst = 2'b01;
  assign axi_ar_bits_lock  = 1'b0;
  assign axi_ar_bits_cache = '0;
  assign axi_ar_bits_prot  = '0;
  assign axi_ar_bits_qos   = '0;
  assign axi_ar_bits_id    = '0;

  assign axi_w_bits_data = exp_data;
  assign axi_w_bits_strb = '1;
  assign axi_w_bits_last = beat_last;

endmodule

// File: tb/tb_axi_mem_tester.sv
// Bench for axi_mem_tester: a reactive AXI slave model that echoes written data,
// driven by a table of test runs plus reset and busy-start sequences.
`timescale 1ns/1ps
module tb_axi_mem_tester;
  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 64;
  localparam int ID_BITS   = 5;
  localparam int STRB_BITS = 8;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [7:0]  burst_len = '0;
  logic [15:0] num_bursts = '0;
  logic [31:0] seed = '0;
  logic busy, done, pass;
  logic [15:0] err_count;
  logic axi_aw_ready = 1'b0, axi_aw_valid, axi_aw_bits_lock;
  logic [31:0] axi_aw_bits_addr, axi_ar_bits_addr;
  logic [7:0] axi_aw_bits_len, axi_ar_bits_len;
  logic [2:0] axi_aw_bits_size, axi_aw_bits_prot, axi_ar_bits_size, axi_ar_bits_prot;
  logic [1:0] axi_aw_bits_burst, axi_ar_bits_burst;
  logic [3:0] axi_aw_bits_cache, axi_aw_bits_qos, axi_ar_bits_cache, axi_ar_bits_qos;
  logic [ID_BITS-1:0] axi_aw_bits_id, axi_ar_bits_id;
  logic axi_w_ready = 1'b0, axi_w_valid, axi_w_bits_last;
  logic [63:0] axi_w_bits_data;
  logic [7:0] axi_w_bits_strb;
  logic axi_b_ready, axi_b_valid = 1'b0;
  logic [1:0] axi_b_bits_resp = '0;
  logic [ID_BITS-1:0] axi_b_bits_id = '0;
  logic axi_ar_ready = 1'b0, axi_ar_valid, axi_ar_bits_lock;
  logic axi_r_ready, axi_r_valid = 1'b0, axi_r_bits_last = 1'b0;
  logic [63:0] axi_r_bits_data = '0;
  logic [1:0] axi_r_bits_resp = '0;
  logic [ID_BITS-1:0] axi_r_bits_id = '0;

  axi_mem_tester #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .ID_BITS(ID_BITS),
                   .STRB_BITS(STRB_BITS)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .burst_len(burst_len), .num_bursts(num_bursts), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .axi_aw_ready(axi_aw_ready), .axi_aw_valid(axi_aw_valid), .axi_aw_bits_addr(axi_aw_bits_addr),
    .axi_aw_bits_len(axi_aw_bits_len), .axi_aw_bits_size(axi_aw_bits_size),
    .axi_aw_bits_burst(axi_aw_bits_burst), .axi_aw_bits_lock(axi_aw_bits_lock),
    .axi_aw_bits_cache(axi_aw_bits_cache), .axi_aw_bits_prot(axi_aw_bits_prot),
    .axi_aw_bits_qos(axi_aw_bits_qos), .axi_aw_bits_id(axi_aw_bits_id),
    .axi_w_ready(axi_w_ready), .axi_w_valid(axi_w_valid), .axi_w_bits_data(axi_w_bits_data),
    .axi_w_bits_strb(axi_w_bits_strb), .axi_w_bits_last(axi_w_bits_last),
    .axi_b_ready(axi_b_ready), .axi_b_valid(axi_b_valid), .axi_b_bits_resp(axi_b_bits_resp),
    .axi_b_bits_id(axi_b_bits_id),
    .axi_ar_ready(axi_ar_ready), .axi_ar_valid(axi_ar_valid), .axi_ar_bits_addr(axi_ar_bits_addr),
    .axi_ar_bits_len(axi_ar_bits_len), .axi_ar_bits_size(axi_ar_bits_size),
    .axi_ar_bits_burst(axi_ar_bits_burst), .axi_ar_bits_lock(axi_ar_bits_lock),
    .axi_ar_bits_cache(axi_ar_bits_cache), .axi_ar_bits_prot(axi_ar_bits_prot),
    .axi_ar_bits_qos(axi_ar_bits_qos), .axi_ar_bits_id(axi_ar_bits_id),
    .axi_r_ready(axi_r_ready), .axi_r_valid(axi_r_valid), .axi_r_bits_data(axi_r_bits_data),
    .axi_r_bits_resp(axi_r_bits_resp), .axi_r_bits_last(axi_r_bits_last),
    .axi_r_bits_id(axi_r_bits_id)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] base;
    logic [7:0]  len;
    logic [15:0] nb;
    logic [31:0] seed;
    bit          stall, flip, bad_b, restart;
    logic [31:0] first_addr, last_addr;
    logic [63:0] first_data;
    int          lat;
    logic [15:0] err_exp;
    logic        pass_exp;
  } vec_t;

  vec_t vecs[7];
  int ncmp = 0, nfail = 0;

  // Slave configuration (written by the test) and logs (written by the slave).
  int cfg_len = 0;
  bit cfg_stall = 0, cfg_flip = 0, cfg_bad_b = 0;
  int clear_req = 0, clear_ack = 0;
  logic [31:0] aw_log[$], ar_log[$];
  logic [63:0] w_log[$];
  bit          wl_log[$];
  int viol = 0, done_cnt = 0, vcnt = 0, w_bursts = 0, b_cnt = 0, r_idx = 0, r_beat = 0;
  bit b_pending = 0, r_pending = 0, b_hs = 0, r_hs = 0, aw_hold = 0, w_hold = 0, ar_hold = 0;
  logic [31:0] aw_prev = '0, ar_prev = '0;
  logic [63:0] w_prev = '0;
  bit w_prev_last = 0;

  function automatic bit rnd();
    return cfg_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Slave: decides everything at the falling edge, so a handshake logged here
  // is the one the DUT sees at the following rising edge.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        axi_aw_ready = 0; axi_w_ready = 0; axi_ar_ready = 0;
        axi_b_valid = 0; axi_r_valid = 0;
        b_pending = 0; r_pending = 0; b_hs = 0; r_hs = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0;
      end else begin
        if (clear_req != clear_ack) begin
          clear_ack = clear_req;
          aw_log.delete(); ar_log.delete(); w_log.delete(); wl_log.delete();
          viol = 0; done_cnt = 0; vcnt = 0; w_bursts = 0; b_cnt = 0; r_idx = 0; r_beat = 0;
          b_pending = 0; r_pending = 0; b_hs = 0; r_hs = 0;
        end
        if (done) done_cnt++;
        if (axi_aw_valid || axi_w_valid || axi_ar_valid) vcnt++;

        if (b_hs) axi_b_valid = 0;
        b_hs = 0;
        if (b_pending) begin
          axi_b_valid     = axi_b_valid | rnd();
          axi_b_bits_resp = cfg_bad_b ? 2'b10 : 2'b00;
          axi_b_bits_id   = '0;
          if (axi_b_valid && axi_b_ready) begin b_hs = 1; b_pending = 0; b_cnt++; end
        end

        if (r_hs) axi_r_valid = 0;
        r_hs = 0;
        if (r_pending) begin
          axi_r_valid     = axi_r_valid | rnd();
          axi_r_bits_data = (r_idx < w_log.size()) ? w_log[r_idx] : '0;
          if (cfg_flip && r_idx == 2) axi_r_bits_data[0] = ~axi_r_bits_data[0];
          axi_r_bits_last = (r_beat == cfg_len);
          axi_r_bits_resp = 2'b00;
          axi_r_bits_id   = '0;
          if (axi_r_valid && axi_r_ready) begin
            r_hs = 1; r_idx++;
            if (r_beat == cfg_len) r_pending = 0;
            r_beat++;
          end
        end

        if (aw_hold && (!axi_aw_valid || axi_aw_bits_addr != aw_prev)) viol++;
        axi_aw_ready = rnd();
        if (axi_aw_valid) begin
          if (axi_aw_bits_len != 8'(cfg_len) || axi_aw_bits_size != 3'd3 ||
              axi_aw_bits_burst != 2'b01 || axi_aw_bits_lock || axi_aw_bits_cache != 0 ||
              axi_aw_bits_prot != 0 || axi_aw_bits_qos != 0 || axi_aw_bits_id != 0) viol++;
          if (axi_aw_ready) begin aw_log.push_back(axi_aw_bits_addr); aw_hold = 0; end
          else begin aw_hold = 1; aw_prev = axi_aw_bits_addr; end
        end else aw_hold = 0;

        if (w_hold && (!axi_w_valid || axi_w_bits_data != w_prev ||
                       axi_w_bits_last != w_prev_last)) viol++;
        axi_w_ready = rnd();
        if (axi_w_valid) begin
          if (aw_log.size() <= w_bursts || axi_w_bits_strb != 8'hFF) viol++;
          if (axi_w_ready) begin
            w_log.push_back(axi_w_bits_data); wl_log.push_back(axi_w_bits_last); w_hold = 0;
            if (axi_w_bits_last) begin w_bursts++; b_pending = 1; end
          end else begin
            w_hold = 1; w_prev = axi_w_bits_data; w_prev_last = axi_w_bits_last;
          end
        end else w_hold = 0;

        if (ar_hold && (!axi_ar_valid || axi_ar_bits_addr != ar_prev)) viol++;
        axi_ar_ready = rnd();
        if (axi_ar_valid) begin
          if (b_cnt <= ar_log.size() || axi_ar_bits_len != 8'(cfg_len) ||
              axi_ar_bits_size != 3'd3 || axi_ar_bits_burst != 2'b01 || axi_ar_bits_lock ||
              axi_ar_bits_cache != 0 || axi_ar_bits_prot != 0 || axi_ar_bits_qos != 0 ||
              axi_ar_bits_id != 0) viol++;
          if (axi_ar_ready) begin
            ar_log.push_back(axi_ar_bits_addr); r_pending = 1; r_beat = 0; ar_hold = 0;
          end else begin ar_hold = 1; ar_prev = axi_ar_bits_addr; end
        end else ar_hold = 0;
      end
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    int n, bad;
    bit got;
    logic [31:0] a;
    logic [63:0] ed;
    cfg_len = int'(v.len); cfg_stall = v.stall; cfg_flip = v.flip; cfg_bad_b = v.bad_b;
    clear_req++;
    @(negedge clock);
    base_addr = v.base; burst_len = v.len; num_bursts = v.nb; seed = v.seed; start = 1;
    @(negedge clock);
    start = 0;
    n = 0; got = 0;
    while (!got && n < 4000) begin
      if (done) got = 1;
      else begin
        @(negedge clock);
        n++;
        if (v.restart && n == 2) begin
          base_addr = 32'hDEAD0000; burst_len = 8'd7; num_bursts = 16'd9; seed = '0; start = 1;
        end else start = 0;
      end
    end
    start = 0;
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    if (v.lat >= 0) chk({tag, "_latency"}, 64'(n), 64'(v.lat));
    @(negedge clock);
    chk({tag, "_done_width_busy"}, 64'({done, busy}), 64'd0);
    chk({tag, "_err_count"}, 64'(err_count), 64'(v.err_exp));
    chk({tag, "_pass"}, 64'(pass), 64'(v.pass_exp));
    repeat (2) @(negedge clock);
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_aw_count"}, 64'(aw_log.size()), 64'(v.nb));
    chk({tag, "_ar_count"}, 64'(ar_log.size()), 64'(v.nb));
    chk({tag, "_w_beats"}, 64'(w_log.size()), 64'(int'(v.nb) * (int'(v.len) + 1)));
    if (v.nb != 0) begin
      chk({tag, "_first_addr"}, 64'(aw_log[0]), 64'(v.first_addr));
      chk({tag, "_last_addr"}, 64'(aw_log[aw_log.size() - 1]), 64'(v.last_addr));
      chk({tag, "_first_data"}, w_log[0], v.first_data);
    end else chk({tag, "_no_traffic"}, 64'(vcnt), 64'd0);
    bad = 0;
    for (int k = 0; k < aw_log.size(); k++) begin
      a = v.base + 32'(k * (int'(v.len) + 1) * 8);
      if (aw_log[k] !== a || k >= ar_log.size() || ar_log[k] !== a) bad++;
    end
    for (int i = 0; i < w_log.size(); i++) begin
      a  = v.base + 32'(i * 8);
      ed = {a ^ v.seed, a ^ v.seed};
      if (w_log[i] !== ed || wl_log[i] !== ((i % (int'(v.len) + 1)) == int'(v.len))) bad++;
    end
    chk({tag, "_model_diffs"}, 64'(bad), 64'd0);
    chk({tag, "_protocol_viol"}, 64'(viol), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bit got;
    vecs[0] = '{32'h00001000, 8'd0, 16'd1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0,
                32'h00001000, 32'h00001000, 64'h00001000_00001000, 5, 16'd0, 1'b1};
    vecs[1] = '{32'hFFFFFFE0, 8'd3, 16'd2, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0,
                32'hFFFFFFE0, 32'h00000000, 64'hFFFFFFE0_FFFFFFE0, 22, 16'd0, 1'b1};
    vecs[2] = '{32'h00002000, 8'd3, 16'd1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 1'b0,
                32'h00002000, 32'h00002000, 64'hA5A585A5_A5A585A5, 11, 16'd2, 1'b0};
    vecs[3] = '{32'hFFFFFFE0, 8'd3, 16'd2, 32'h12345678, 1'b1, 1'b0, 1'b0, 1'b0,
                32'hFFFFFFE0, 32'h00000000, 64'hEDCBA998_EDCBA998, -1, 16'd0, 1'b1};
    vecs[4] = '{32'h00005000, 8'd2, 16'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0,
                32'h00000000, 32'h00000000, 64'h0, 0, 16'd0, 1'b1};
    vecs[5] = '{32'h00000100, 8'd1, 16'd3, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1,
                32'h00000100, 32'h00000120, 64'hFFFFFEFF_FFFFFEFF, -1, 16'd0, 1'b1};
    vecs[6] = '{32'h00000040, 8'd0, 16'd3, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0,
                32'h00000040, 32'h00000050, 64'h00000040_00000040, -1, 16'd3, 1'b0};

    repeat (3) @(negedge clock);
    chk("reset_ctl", 64'({busy, done, pass, axi_aw_valid, axi_w_valid, axi_ar_valid,
                          axi_b_ready, axi_r_ready}), 64'd0);
    chk("reset_err_count", 64'(err_count), 64'd0);
    reset_n = 1;
    @(negedge clock);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted while W beat 1 is on the bus.
    cfg_len = 3; cfg_stall = 0; cfg_flip = 0; cfg_bad_b = 0;
    clear_req++;
    @(negedge clock);
    base_addr = 32'h3000; burst_len = 8'd3; num_bursts = 16'd1; seed = '0; start = 1;
    @(negedge clock);
    start = 0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clock); #1;
      if (axi_w_valid && axi_w_bits_data[31:0] == 32'h00003008) got = 1;
    end
    chk("rst_w_beat1_seen", 64'(got), 64'd1);
    #1 reset_n = 0;
    #1;
    chk("rst_async_ctl", 64'({axi_w_valid, axi_aw_valid, axi_ar_valid, axi_b_ready,
                              axi_r_ready, busy, done, pass}), 64'd0);
    chk("rst_async_err", 64'(err_count), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1;
    c = 0;
    repeat (6) begin
      @(negedge clock);
      if (axi_aw_valid || axi_w_valid || axi_ar_valid || busy || done) c++;
    end
    chk("rst_idle_after_release", 64'(c), 64'd0);
    run_vec(vecs[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
